// File: rtl/time_set_editor.sv
// time_set_editor: button-driven editor for the time calculator load bus.
// On KEY_SET it snapshots the current time/date (or the alarm), cleans up any
// out-of-range fields, and lets the user step one field at a time with UP/DOWN.
// A KEY_SET on the last field commits: mode is held high for COMMIT_CYCLES
// cycles so the calculator loads the edited values.
// Ports:
//   clk, reset                       clock, async active-high reset
//   key_set/up/down/cancel           1-cycle debounced key pulses
//   target                           0 = time+date, 1 = alarm (sampled on entry)
//   cur_time/cur_date/cur_alarm      current values from the calculator
//   edit_time/edit_date/edit_alarm   working values -> calculator load inputs
//   mode                             load strobe, high only while committing
//   mode_state                       latched target
//   setting                          high while editing or committing
//   field                            cursor: 0 HOUR,1 MIN,2 SEC,3 YEAR,4 MONTH,5 DAY
module time_set_editor #(
    parameter int unsigned COMMIT_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_set,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_cancel,
    input  logic        target,
    input  logic [17:0] cur_time,
    input  logic [15:0] cur_date,
    input  logic [16:0] cur_alarm,
    output logic [17:0] edit_time,
    output logic [15:0] edit_date,
    output logic [16:0] edit_alarm,
    output logic        mode,
    output logic        mode_state,
    output logic        setting,
    output logic [2:0]  field
);

    localparam int unsigned CW = (COMMIT_CYCLES > 1) ? $clog2(COMMIT_CYCLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    state_t        state;
    logic [CW-1:0] commit_cnt;
    logic [TW-1:0] idle_cnt;

    // Working registers
    logic [4:0] hour, a_hour;
    logic [5:0] minute, second, a_min, a_sec;
    logic [6:0] year;
    logic [3:0] month;
    logic [4:0] day;

    // Sanitised snapshot and stepped values
    logic [4:0] s_hour, s_ahour, s_max, s_day;
    logic [5:0] s_min, s_sec, s_amin, s_asec;
    logic [6:0] s_year;
    logic [3:0] s_month;
    logic [4:0] n_hour, n_ahour, n_day, n_max;
    logic [5:0] n_min, n_sec, n_amin, n_asec;
    logic [6:0] n_year;
    logic [3:0] n_month;

    // Meridian of the incoming time is recomputed, never copied
    logic unused_meridian;
    assign unused_meridian = cur_time[17];

    assign edit_time  = {hour >= 5'd12, hour, minute, second};
    assign edit_date  = {year, month, day};
    assign edit_alarm = {a_hour, a_min, a_sec};

    // Days in month, 20YY leap years
    function automatic logic [4:0] days_in(input logic [3:0] m, input logic [6:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: days_in = 5'd30;
            4'd2:                    days_in = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 days_in = 5'd31;
        endcase
    endfunction

    // One wrapping step inside [lo, hi]
    function automatic logic [6:0] step(input logic [6:0] v, input logic [6:0] lo,
                                        input logic [6:0] hi, input logic up);
        if (up) step = (v >= hi) ? lo : v + 7'd1;
        else    step = (v <= lo) ? hi : v - 7'd1;
    endfunction

    // Snapshot clean-up of out-of-range calculator values
    always_comb begin
        s_hour  = (cur_time[16:12] > 5'd23) ? 5'd0 : cur_time[16:12];
        s_min   = (cur_time[11:6]  > 6'd59) ? 6'd0 : cur_time[11:6];
        s_sec   = (cur_time[5:0]   > 6'd59) ? 6'd0 : cur_time[5:0];
        s_year  = (cur_date[15:9]  > 7'd99) ? 7'd0 : cur_date[15:9];
        s_month = (cur_date[8:5] == 4'd0 || cur_date[8:5] > 4'd12) ? 4'd1 : cur_date[8:5];
        s_max   = days_in(s_month, s_year);
        if (cur_date[4:0] == 5'd0)    s_day = 5'd1;
        else if (cur_date[4:0] > s_max) s_day = s_max;
        else                          s_day = cur_date[4:0];
        s_ahour = (cur_alarm[16:12] > 5'd23) ? 5'd0 : cur_alarm[16:12];
        s_amin  = (cur_alarm[11:6]  > 6'd59) ? 6'd0 : cur_alarm[11:6];
        s_asec  = (cur_alarm[5:0]   > 6'd59) ? 6'd0 : cur_alarm[5:0];
    end

    // UP/DOWN result for the field under the cursor; month/year changes clamp day
    always_comb begin
        n_hour  = hour;
        n_min   = minute;
        n_sec   = second;
        n_year  = year;
        n_month = month;
        n_day   = day;
        n_ahour = a_hour;
        n_amin  = a_min;
        n_asec  = a_sec;
        n_max   = days_in(month, year);
        if (key_up ^ key_down) begin
            if (mode_state) begin
                case (field)
                    3'd0:    n_ahour = 5'(step(7'(a_hour), 7'd0, 7'd23, key_up));
                    3'd1:    n_amin  = 6'(step(7'(a_min),  7'd0, 7'd59, key_up));
                    3'd2:    n_asec  = 6'(step(7'(a_sec),  7'd0, 7'd59, key_up));
                    default: ;
                endcase
            end else begin
                case (field)
                    3'd0: n_hour = 5'(step(7'(hour),   7'd0, 7'd23, key_up));
                    3'd1: n_min  = 6'(step(7'(minute), 7'd0, 7'd59, key_up));
                    3'd2: n_sec  = 6'(step(7'(second), 7'd0, 7'd59, key_up));
                    3'd3: begin
                        n_year = step(year, 7'd0, 7'd99, key_up);
                        n_max  = days_in(month, n_year);
                        n_day  = (day > n_max) ? n_max : day;
                    end
                    3'd4: begin
                        n_month = 4'(step(7'(month), 7'd1, 7'd12, key_up));
                        n_max   = days_in(n_month, year);
                        n_day   = (day > n_max) ? n_max : day;
                    end
                    3'd5: n_day = 5'(step(7'(day), 7'd1, 7'(n_max), key_up));
                    default: ;
                endcase
            end
        end
    end

    // Editor FSM with registered outputs and working registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            commit_cnt <= '0;
            idle_cnt   <= '0;
            mode       <= 1'b0;
            mode_state <= 1'b0;
            setting    <= 1'b0;
            field      <= 3'd0;
            hour       <= '0;
            minute     <= '0;
            second     <= '0;
            year       <= '0;
            month      <= '0;
            day        <= '0;
            a_hour     <= '0;
            a_min      <= '0;
            a_sec      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mode    <= 1'b0;
                    setting <= 1'b0;
                    field   <= 3'd0;
                    if (key_set && !key_cancel) begin
                        state      <= EDIT;
                        setting    <= 1'b1;
                        mode_state <= target;
                        idle_cnt   <= '0;
                        if (target) begin
                            a_hour <= s_ahour;
                            a_min  <= s_amin;
                            a_sec  <= s_asec;
                        end else begin
                            hour   <= s_hour;
                            minute <= s_min;
                            second <= s_sec;
                            year   <= s_year;
                            month  <= s_month;
                            day    <= s_day;
                        end
                    end
                end
                EDIT: begin
                    if (key_cancel) begin
                        state   <= IDLE;
                        setting <= 1'b0;
                        field   <= 3'd0;
                    end else if (key_set) begin
                        idle_cnt <= '0;
                        if (field == (mode_state ? 3'd2 : 3'd5)) begin
                            state      <= COMMIT;
                            mode       <= 1'b1;
                            commit_cnt <= '0;
                        end else begin
                            field <= field + 3'd1;
                        end
                    end else if (key_up || key_down) begin
                        idle_cnt <= '0;
                        hour     <= n_hour;
                        minute   <= n_min;
                        second   <= n_sec;
                        year     <= n_year;
                        month    <= n_month;
                        day      <= n_day;
                        a_hour   <= n_ahour;
                        a_min    <= n_amin;
                        a_sec    <= n_asec;
                    end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state   <= IDLE;
                        setting <= 1'b0;
                        field   <= 3'd0;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                COMMIT: begin
                    if (commit_cnt == CW'(COMMIT_CYCLES - 1)) begin
                        state   <= IDLE;
                        mode    <= 1'b0;
                        setting <= 1'b0;
                        field   <= 3'd0;
                    end else begin
                        commit_cnt <= commit_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_editor.sv
// Testbench for time_set_editor: directed scenarios plus randomized key
// traffic checked against a behavioural model that works on plain integers.
module tb_time_set_editor;

    localparam int TO = 3000;
    localparam int CC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_set = 1'b0, key_up = 1'b0, key_down = 1'b0, key_cancel = 1'b0;
    logic        target = 1'b0;
    logic [17:0] cur_time = '0;
    logic [15:0] cur_date = '0;
    logic [16:0] cur_alarm = '0;
    logic [17:0] edit_time;
    logic [15:0] edit_date;
    logic [16:0] edit_alarm;
    logic        mode, mode_state, setting;
    logic [2:0]  field;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: phase 0 idle, 1 editing, 2 committing
    int m_st, m_field, m_ms, m_idle, m_left;
    int m_hr, m_mi, m_se, m_yr, m_mo, m_dy, m_ah, m_am, m_as;

    always #5 clk = ~clk;

    time_set_editor #(.COMMIT_CYCLES(CC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .key_set(key_set), .key_up(key_up), .key_down(key_down), .key_cancel(key_cancel),
        .target(target), .cur_time(cur_time), .cur_date(cur_date), .cur_alarm(cur_alarm),
        .edit_time(edit_time), .edit_date(edit_date), .edit_alarm(edit_alarm),
        .mode(mode), .mode_state(mode_state), .setting(setting), .field(field)
    );

    function automatic int mdays(int m, int y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic logic [17:0] exp_time();
        return {(m_hr >= 12), 5'(m_hr), 6'(m_mi), 6'(m_se)};
    endfunction
    function automatic logic [15:0] exp_date();
        return {7'(m_yr), 4'(m_mo), 5'(m_dy)};
    endfunction
    function automatic logic [16:0] exp_alarm();
        return {5'(m_ah), 6'(m_am), 6'(m_as)};
    endfunction

    task automatic model_reset();
        m_st = 0; m_field = 0; m_ms = 0; m_idle = 0; m_left = 0;
        m_hr = 0; m_mi = 0; m_se = 0; m_yr = 0; m_mo = 0; m_dy = 0;
        m_ah = 0; m_am = 0; m_as = 0;
    endtask

    task automatic model_adjust(int delta);
        int mx;
        if (m_ms != 0) begin
            if (m_field == 0) m_ah = (m_ah + delta + 24) % 24;
            if (m_field == 1) m_am = (m_am + delta + 60) % 60;
            if (m_field == 2) m_as = (m_as + delta + 60) % 60;
        end else begin
            case (m_field)
                0: m_hr = (m_hr + delta + 24) % 24;
                1: m_mi = (m_mi + delta + 60) % 60;
                2: m_se = (m_se + delta + 60) % 60;
                3: m_yr = (m_yr + delta + 100) % 100;
                4: m_mo = (m_mo - 1 + delta + 12) % 12 + 1;
                5: begin
                    mx = mdays(m_mo, m_yr);
                    m_dy = (m_dy - 1 + delta + mx) % mx + 1;
                end
                default: ;
            endcase
            if (m_dy > mdays(m_mo, m_yr)) m_dy = mdays(m_mo, m_yr);
        end
    endtask

    // Advance the model by one clock given this cycle's keys and inputs
    task automatic model_step(bit s, bit u, bit d, bit c);
        int mx;
        if (m_st == 0) begin
            if (s && !c) begin
                m_st = 1; m_field = 0; m_idle = 0; m_ms = int'(target);
                if (target) begin
                    m_ah = int'(cur_alarm[16:12]); if (m_ah > 23) m_ah = 0;
                    m_am = int'(cur_alarm[11:6]);  if (m_am > 59) m_am = 0;
                    m_as = int'(cur_alarm[5:0]);   if (m_as > 59) m_as = 0;
                end else begin
                    m_hr = int'(cur_time[16:12]); if (m_hr > 23) m_hr = 0;
                    m_mi = int'(cur_time[11:6]);  if (m_mi > 59) m_mi = 0;
                    m_se = int'(cur_time[5:0]);   if (m_se > 59) m_se = 0;
                    m_yr = int'(cur_date[15:9]);  if (m_yr > 99) m_yr = 0;
                    m_mo = int'(cur_date[8:5]);   if (m_mo < 1 || m_mo > 12) m_mo = 1;
                    m_dy = int'(cur_date[4:0]);   if (m_dy < 1) m_dy = 1;
                    mx = mdays(m_mo, m_yr);
                    if (m_dy > mx) m_dy = mx;
                end
            end
        end else if (m_st == 1) begin
            if (c) begin
                m_st = 0; m_field = 0;
            end else if (s) begin
                m_idle = 0;
                if (m_field == ((m_ms != 0) ? 2 : 5)) begin
                    m_st = 2; m_left = CC;
                end else m_field++;
            end else if (u || d) begin
                m_idle = 0;
                if (u != d) model_adjust(u ? 1 : -1);
            end else begin
                m_idle++;
                if (m_idle == TO) begin m_st = 0; m_field = 0; end
            end
        end else begin
            m_left--;
            if (m_left == 0) begin m_st = 0; m_field = 0; end
        end
    endtask

    // Drive one cycle of keys, update the model, sample 1 time unit after the edge
    task automatic cyc(bit s, bit u, bit d, bit c);
        key_set = s; key_up = u; key_down = d; key_cancel = c;
        model_step(s, u, d, c);
        @(posedge clk);
        #1;
        key_set = 1'b0; key_up = 1'b0; key_down = 1'b0; key_cancel = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (edit_time !== 18'd0) begin n_bad++; $display("FAIL reset_time got=%h exp=0", edit_time); end
        n_cmp++; if (edit_date !== 16'd0) begin n_bad++; $display("FAIL reset_date got=%h exp=0", edit_date); end
        n_cmp++; if (edit_alarm !== 17'd0) begin n_bad++; $display("FAIL reset_alarm got=%h exp=0", edit_alarm); end
        n_cmp++; if ({mode, mode_state, setting, field} !== 6'd0)
            begin n_bad++; $display("FAIL reset_ctrl got=%b exp=000000", {mode, mode_state, setting, field}); end
        reset = 1'b0;
        cyc(0, 1, 0, 1);
        n_cmp++; if (setting !== 1'b0) begin n_bad++; $display("FAIL idle_ignores_keys setting=%b exp=0", setting); end
    endtask

    task automatic test_time_edit();
        target = 1'b0;
        cur_time = {1'b0, 5'd11, 6'd59, 6'd30};
        cur_date = {7'd24, 4'd2, 5'd29};
        cyc(1, 0, 0, 0);
        n_cmp++; if ({setting, field, mode} !== 5'b1_000_0)
            begin n_bad++; $display("FAIL enter_edit got=%b exp=10000", {setting, field, mode}); end
        n_cmp++; if (edit_time !== {1'b0, 5'd11, 6'd59, 6'd30})
            begin n_bad++; $display("FAIL snapshot_time got=%h exp=%h", edit_time, {1'b0, 5'd11, 6'd59, 6'd30}); end
        cyc(0, 1, 0, 0);
        n_cmp++; if (edit_time !== {1'b1, 5'd12, 6'd59, 6'd30})
            begin n_bad++; $display("FAIL hour_up_meridian got=%h exp=%h", edit_time, {1'b1, 5'd12, 6'd59, 6'd30}); end
        repeat (5) cyc(1, 0, 0, 0);
        n_cmp++; if (field !== 3'd5) begin n_bad++; $display("FAIL field_day got=%0d exp=5", field); end
        cyc(0, 1, 0, 0);
        n_cmp++; if (edit_date !== {7'd24, 4'd2, 5'd1})
            begin n_bad++; $display("FAIL day_wrap_leap got=%h exp=%h", edit_date, {7'd24, 4'd2, 5'd1}); end
        cyc(1, 0, 0, 0);
        n_cmp++; if ({mode, setting} !== 2'b11) begin n_bad++; $display("FAIL commit_c1 got=%b exp=11", {mode, setting}); end
        cyc(0, 0, 0, 0);
        n_cmp++; if ({mode, setting} !== 2'b11) begin n_bad++; $display("FAIL commit_c2 got=%b exp=11", {mode, setting}); end
        cyc(0, 0, 0, 0);
        n_cmp++; if ({mode, setting, field} !== 5'b0) begin n_bad++; $display("FAIL commit_end got=%b exp=00000", {mode, setting, field}); end
        n_cmp++; if (edit_date !== {7'd24, 4'd2, 5'd1})
            begin n_bad++; $display("FAIL hold_after_commit got=%h exp=%h", edit_date, {7'd24, 4'd2, 5'd1}); end
    endtask

    task automatic test_month_clamp();
        target = 1'b0;
        cur_date = {7'd23, 4'd1, 5'd31};
        cyc(1, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        n_cmp++; if (edit_date !== {7'd23, 4'd2, 5'd28})
            begin n_bad++; $display("FAIL month_clamp28 got=%h exp=%h", edit_date, {7'd23, 4'd2, 5'd28}); end
        cyc(0, 0, 0, 1);
        n_cmp++; if ({setting, mode} !== 2'b00 || edit_date !== {7'd23, 4'd2, 5'd28})
            begin n_bad++; $display("FAIL cancel_hold got=%b/%h exp=00/%h", {setting, mode}, edit_date, {7'd23, 4'd2, 5'd28}); end
        cyc(1, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        n_cmp++; if (edit_date !== {7'd24, 4'd2, 5'd29})
            begin n_bad++; $display("FAIL month_clamp29 got=%h exp=%h", edit_date, {7'd24, 4'd2, 5'd29}); end
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_alarm();
        target = 1'b1;
        cur_alarm = '0;
        cyc(1, 0, 0, 0);
        n_cmp++; if (mode_state !== 1'b1) begin n_bad++; $display("FAIL mode_state got=%b exp=1", mode_state); end
        cyc(0, 0, 1, 0);
        n_cmp++; if (edit_alarm !== {5'd23, 6'd0, 6'd0})
            begin n_bad++; $display("FAIL alarm_hour_down got=%h exp=%h", edit_alarm, {5'd23, 6'd0, 6'd0}); end
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        n_cmp++; if ({mode, setting} !== 2'b11) begin n_bad++; $display("FAIL alarm_commit got=%b exp=11", {mode, setting}); end
        n_cmp++; if (edit_time !== {1'b0, 5'd11, 6'd59, 6'd30})
            begin n_bad++; $display("FAIL alarm_time_untouched got=%h exp=%h", edit_time, {1'b0, 5'd11, 6'd59, 6'd30}); end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        n_cmp++; if ({mode, setting} !== 2'b00) begin n_bad++; $display("FAIL alarm_commit_end got=%b exp=00", {mode, setting}); end
    endtask

    task automatic test_cancel_priority();
        bit saw_mode;
        target = 1'b0;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 0);
        n_cmp++; if (edit_time !== {1'b0, 5'd11, 6'd59, 6'd30})
            begin n_bad++; $display("FAIL up_down_nochange got=%h exp=%h", edit_time, {1'b0, 5'd11, 6'd59, 6'd30}); end
        saw_mode = 1'b0;
        cyc(1, 0, 0, 1);
        if (mode) saw_mode = 1'b1;
        n_cmp++; if ({setting, field} !== 4'b0) begin n_bad++; $display("FAIL cancel_over_set got=%b exp=0000", {setting, field}); end
        repeat (4) begin cyc(0, 0, 0, 0); if (mode) saw_mode = 1'b1; end
        n_cmp++; if (saw_mode !== 1'b0) begin n_bad++; $display("FAIL cancel_no_mode got=%b exp=0", saw_mode); end
    endtask

    task automatic test_timeout();
        bit saw_mode;
        target = 1'b0;
        saw_mode = 1'b0;
        cyc(1, 0, 0, 0);
        repeat (TO - 1) begin cyc(0, 0, 0, 0); if (mode) saw_mode = 1'b1; end
        n_cmp++; if (setting !== 1'b1) begin n_bad++; $display("FAIL timeout_early setting=%b exp=1", setting); end
        cyc(0, 0, 0, 0);
        if (mode) saw_mode = 1'b1;
        n_cmp++; if (setting !== 1'b0) begin n_bad++; $display("FAIL timeout_expire setting=%b exp=0", setting); end
        n_cmp++; if (saw_mode !== 1'b0) begin n_bad++; $display("FAIL timeout_no_mode got=%b exp=0", saw_mode); end
    endtask

    task automatic test_reset_mid_commit();
        bit saw_mode;
        target = 1'b0;
        cyc(1, 0, 0, 0);
        repeat (6) cyc(1, 0, 0, 0);
        n_cmp++; if (mode !== 1'b1) begin n_bad++; $display("FAIL precommit mode=%b exp=1", mode); end
        reset = 1'b1;
        #1;
        model_reset();
        n_cmp++; if ({mode, setting, edit_time, edit_date, edit_alarm} !== 53'd0)
            begin n_bad++; $display("FAIL reset_mid_commit got=%h exp=0", {mode, setting, edit_time, edit_date, edit_alarm}); end
        @(posedge clk);
        #2;
        reset = 1'b0;
        saw_mode = 1'b0;
        repeat (4) begin cyc(0, 0, 0, 0); if (mode || setting) saw_mode = 1'b1; end
        n_cmp++; if (saw_mode !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle got=%b exp=0", saw_mode); end
    endtask

    task automatic test_random();
        logic [53:0] got, exp;
        for (int i = 0; i < 1500; i++) begin
            target = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                cur_time  = 18'($urandom);
                cur_date  = 16'($urandom);
                cur_alarm = 17'($urandom);
            end else begin
                cur_time  = {1'b0, 5'($urandom_range(0, 23)), 6'($urandom_range(0, 59)), 6'($urandom_range(0, 59))};
                cur_date  = {7'($urandom_range(0, 99)), 4'($urandom_range(1, 12)), 5'($urandom_range(1, 31))};
                cur_alarm = {5'($urandom_range(0, 23)), 6'($urandom_range(0, 59)), 6'($urandom_range(0, 59))};
            end
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
            got = {edit_time, edit_date, edit_alarm, mode, mode_state, setting};
            exp = {exp_time(), exp_date(), exp_alarm(), m_st == 2, m_ms != 0, m_st != 0};
            n_cmp++;
            if (got !== exp || field !== 3'(m_field)) begin
                n_bad++;
                $display("FAIL random_cycle%0d got=%h field=%0d exp=%h field=%0d", i, got, field, exp, m_field);
            end
        end
    endtask

    initial begin
        test_reset();
        test_time_edit();
        test_month_clamp();
        test_alarm();
        test_cancel_priority();
        test_timeout();
        test_reset_mid_commit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
